// File: rtl/crc32_rx_check.sv
// crc32_rx_check: receive-side FCS checker for the 32-bit MAC datapath.
// Runs the reflected CRC-32 over every received byte, including the FCS.
// Strips the FCS from the forwarded stream using a one-beat hold register.
// Flags each frame good/bad on its final output beat.
module crc32_rx_check #(
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_data_keep,
  input  logic                    i_data_valid,
  input  logic                    i_data_last,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_data_keep,
  output logic                    o_data_valid,
  output logic                    o_data_last,
  output logic                    o_crc_good,
  output logic                    o_crc_bad
);

  localparam int                 NB      = DATA_WIDTH / 8;
  localparam logic [CRC_WIDTH-1:0] POLY    = CRC_WIDTH'(32'hEDB88320);
  localparam logic [CRC_WIDTH-1:0] INIT    = '1;
  localparam logic [CRC_WIDTH-1:0] RESIDUE = CRC_WIDTH'(32'hDEBB20E3);

  logic [CRC_WIDTH-1:0]  crc_q;
  logic [DATA_WIDTH-1:0] held_q;
  logic                  held_vld;
  logic                  err_q;

  logic [CRC_WIDTH-1:0]  crc_fold;
  logic                  keep_ok;
  logic [NB-1:0]         last_mask;
  logic                  frame_ok;

  // One byte through the LSB-first reflected CRC, bit-serial unrolled.
  function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [7:0] d);
    logic [CRC_WIDTH-1:0] r;
    r = c ^ CRC_WIDTH'(d);
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // Fold enabled bytes in wire order, classify the keep pattern, pick the strip mask.
  always_comb begin
    crc_fold  = crc_q;
    keep_ok   = 1'b0;
    last_mask = '1;
    for (int b = 0; b < NB; b++)
      if (i_data_keep[b]) crc_fold = crc_byte(crc_fold, i_data[b*8 +: 8]);
    if (!i_data_last) begin
      keep_ok = (i_data_keep == NB'(4'b1111));
    end else begin
      // Illegal last-beat keeps fall through to the full-word strip.
      case (i_data_keep)
        NB'(4'b0001): begin keep_ok = 1'b1; last_mask = NB'(4'b0001); end
        NB'(4'b0011): begin keep_ok = 1'b1; last_mask = NB'(4'b0011); end
        NB'(4'b0111): begin keep_ok = 1'b1; last_mask = NB'(4'b0111); end
        NB'(4'b1111): begin keep_ok = 1'b1; last_mask = NB'(4'b1111); end
        default:      begin keep_ok = 1'b0; last_mask = NB'(4'b1111); end
      endcase
    end
    frame_ok = !(err_q || !keep_ok) && (crc_fold == RESIDUE);
  end

  // CRC state, hold register, sticky error and registered output beat.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      crc_q        <= INIT;
      held_q       <= '0;
      held_vld     <= 1'b0;
      err_q        <= 1'b0;
      o_data       <= '0;
      o_data_keep  <= '0;
      o_data_valid <= 1'b0;
      o_data_last  <= 1'b0;
      o_crc_good   <= 1'b0;
      o_crc_bad    <= 1'b0;
    end else begin
      o_data       <= '0;
      o_data_keep  <= '0;
      o_data_valid <= 1'b0;
      o_data_last  <= 1'b0;
      o_crc_good   <= 1'b0;
      o_crc_bad    <= 1'b0;
      if (i_data_valid) begin
        if (!i_data_last) begin
          crc_q    <= crc_fold;
          err_q    <= err_q | ~keep_ok;
          held_q   <= i_data;
          held_vld <= 1'b1;
          if (held_vld) begin
            o_data       <= held_q;
            o_data_keep  <= '1;
            o_data_valid <= 1'b1;
          end
        end else begin
          // Frame ends here: reload so the next beat starts a fresh frame.
          crc_q        <= INIT;
          err_q        <= 1'b0;
          held_vld     <= 1'b0;
          o_data_valid <= 1'b1;
          o_data_last  <= 1'b1;
          if (held_vld) begin
            o_data      <= held_q;
            o_data_keep <= last_mask;
            o_crc_good  <= frame_ok;
            o_crc_bad   <= !frame_ok;
          end else begin
            // Runt: nothing but FCS bytes arrived, so there is no payload to forward.
            o_crc_bad   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/crc32_rx_check.md
# crc32_rx_check

Receive-side FCS checker for the 32-bit MAC datapath, the counterpart to the TX `crc32` generator. It sits between the RX decapsulation stage and the user stream. It computes the reflected Ethernet CRC-32 over every received byte, including the trailing 4-byte FCS. It strips the FCS from the forwarded stream and flags each frame good or bad on its final output beat.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width in bits; only 32 is supported.
- CRC_WIDTH, 32, CRC register width.

Ports:
- i_clk  in  1  system clock; all logic is rising-edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data  in  32  input word; byte 0 is `[7:0]` and is first on the wire.
- i_data_keep  in  4  byte enables; contiguous from the LSB.
- i_data_valid  in  1  beat qualifier; there is no backpressure.
- i_data_last  in  1  marks the final beat of the frame, which includes the FCS.
- o_data  out  32  forwarded word with the FCS removed.
- o_data_keep  out  4  forwarded byte enables.
- o_data_valid  out  1  output beat qualifier.
- o_data_last  out  1  final output beat of the frame.
- o_crc_good  out  1  one-cycle pulse with `o_data_last` when the frame is valid.
- o_crc_bad  out  1  one-cycle pulse with `o_data_last` when the frame is invalid.

## Operation
- CRC algorithm: reflected CRC-32, polynomial 0xEDB88320, processed LSB-first.
  - The running state register resets to 0xFFFFFFFF.
  - Each valid beat folds in only the bytes whose keep bit is set, in byte order 0..3.
- Frame check: after the last beat, the state including the FCS bytes must equal the residue 0xDEBB20E3 (no final XOR applied). Any other value means bad.
- State control: the CRC state reloads to 0xFFFFFFFF in the cycle after any `i_data_last` beat.
- Beat legality:
  - Non-last beats must have keep = 1111.
  - Last beats must have keep ∈ {0001, 0011, 0111, 1111}.
- Hold register: one beat of storage, holding the most recent non-last beat plus a held-valid flag.
  - When a non-last beat arrives and the register is held, the held word is emitted with keep = 1111 and last = 0; the new beat is then stored.
  - When a non-last beat arrives and the register is empty, the beat is stored and nothing is emitted.
- FCS stripping when the last beat arrives with k valid bytes (k = 1..4):
  - The FCS occupies held bytes k..3 plus last-beat bytes 0..k-1, or the whole last beat when k = 4.
  - The held word is emitted with keep = lower-k mask (k = 4 gives 1111), last = 1, and good/bad.
  - The last beat's own data is never forwarded.
- Runt: a last beat with no held word (total frame ≤ 4 bytes) emits one beat with keep = 0000, data = 0, last = 1, and crc_bad = 1.
- Sticky error flag: any illegal keep in the frame sets the flag.
  - The frame then ends with crc_bad = 1, regardless of the residue.
  - An illegal last-beat keep is stripped as if k = 4.
  - The flag clears after the last beat.
- Exclusivity: o_crc_good and o_crc_bad are mutually exclusive, and both are 0 on any beat without last.
- Input gaps: beats with i_data_valid = 0 change nothing; output is emitted only as described above.

## Timing
- All outputs are registered.
- Reset values: o_data = 0, o_data_keep = 0, o_data_valid = 0, o_data_last = 0, o_crc_good = 0, o_crc_bad = 0. The CRC state is 0xFFFFFFFF, and the held-valid and error flags are 0.
- Latency:
  - The beat for input n appears one cycle after input beat n+1 is sampled.
  - The final (last) output beat appears exactly one cycle after the input last beat.
- Non-last output beats appear only when the following input beat arrives, so input gaps propagate to the output.
- Back-to-back frames: a new frame's first beat may arrive in the cycle immediately after a last beat. The first beat of the new frame uses the reloaded state, with no bubble required.
- Reset mid-frame: reset discards the held word, state and flag. Remaining beats of the interrupted frame are treated as a new frame; no output is produced for the discarded portion.

## Test plan
- "123456789" plus FCS (13 bytes):
  - Stimulus: 0x34333231, 0x38373635, 0xF4392639, then 0x000000CB with keep 0001 and last.
  - Required output: the first two words with keep 1111, then 0xF4392639 with keep 0001, last, and crc_good.
- Same frame with bit 0 of byte 4 flipped (word 1 = 0x38373634) → identical framing, crc_bad = 1, crc_good = 0.
- Sweep payloads of 64..1500 random bytes across all four k values, with the FCS from the TX `crc32` model:
  - Forwarded bytes must equal the payload exactly, with crc_good on every frame.
  - Also run back-to-back frames with no idle beat.
- Runt: a single beat 0x11223344 with keep 1111 and last → one output beat with keep 0000, last, and crc_bad.
- Keep violation: a non-last beat with keep 0011 mid-frame in an otherwise correct frame → crc_bad on its last beat. The next correct frame → crc_good.
- Reset asserted after 2 beats of a frame:
  - All outputs are 0 immediately (asynchronously).
  - After release, a complete valid frame → crc_good, with no stale beat emitted.
